sl3_tx_framer: RTL and testbench

Transmit-side framer that sits directly upstream of the SL3 link data port. It accepts user payload streams of 128-bit phits and buffers each whole packet. It then emits the packet on the SL3 data interface (valid / 128-bit data / last) as one header phit followed by the payload phits. Truncation of oversize packets, per-link sequence numbering and link-up gating are handled here so the SL3 core sees only well-formed, length-tagged frames.

---
 rtl/sl3_tx_framer.sv | 179 +++++++++++++++++
 tb/tb_sl3_tx_framer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sl3_tx_framer.sv
// SL3 transmit framer: buffers whole payload packets, then emits a header phit
// plus payload on the SL3 data port with truncation, sequence numbering and link gating.
module sl3_tx_framer #(
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_PHITS  = 64,
    parameter int DESC_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   node_id,
    input  logic         link_up,
    input  logic         in_valid,
    input  logic [127:0] in_data,
    input  logic         in_last,
    input  logic [7:0]   in_dst,
    output logic         in_ready,
    output logic         out_valid,
    output logic [127:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic [31:0]  pkt_cnt,
    output logic [15:0]  trunc_cnt
);
    localparam int PAW = $clog2(FIFO_DEPTH);
    localparam int DAW = $clog2(DESC_DEPTH);
    localparam int LW  = $clog2(MAX_PHITS + 1);
    localparam int DW  = 8 + LW + 1;

    typedef enum logic {WR_ACCEPT, WR_DISCARD} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_HDR, RD_PAY} rd_state_t;

    wr_state_t r_wr_state, w_wr_next;
    rd_state_t r_rd_state, w_rd_next;

    logic [128:0]   r_pay_mem [FIFO_DEPTH];
    logic [PAW:0]   r_pay_wp, r_pay_rp;
    logic [DW-1:0]  r_desc_mem [DESC_DEPTH];
    logic [DAW:0]   r_desc_wp, r_desc_rp;

    logic           r_live;
    logic [LW-1:0]  r_len;
    logic [7:0]     r_dst;
    logic [15:0]    r_seq;
    logic [31:0]    r_pkt_cnt;
    logic [15:0]    r_trunc_cnt;

    logic           w_pay_full, w_desc_full, w_desc_empty;
    logic           w_pay_push, w_pay_pop, w_desc_push, w_desc_pop;
    logic [LW-1:0]  w_len_inc;
    logic           w_last_eff;
    logic [7:0]     w_dst_cur;
    logic [128:0]   w_pay_head;
    logic [7:0]     w_hd_dst;
    logic [LW-1:0]  w_hd_len;
    logic           w_hd_trunc;
    logic [127:0]   w_header;

    assign w_pay_full   = (r_pay_wp[PAW] != r_pay_rp[PAW]) &&
                          (r_pay_wp[PAW-1:0] == r_pay_rp[PAW-1:0]);
    assign w_desc_full  = (r_desc_wp[DAW] != r_desc_rp[DAW]) &&
                          (r_desc_wp[DAW-1:0] == r_desc_rp[DAW-1:0]);
    assign w_desc_empty = (r_desc_wp == r_desc_rp);

    assign w_len_inc  = r_len + 1'b1;
    assign w_last_eff = in_last | (w_len_inc == LW'(MAX_PHITS));
    assign w_dst_cur  = (r_len == '0) ? in_dst : r_dst;

    // Show-ahead heads: both FIFOs are read combinationally at the read pointer.
    assign w_pay_head = r_pay_mem[r_pay_rp[PAW-1:0]];
    assign {w_hd_dst, w_hd_len, w_hd_trunc} = r_desc_mem[r_desc_rp[DAW-1:0]];
    assign w_header = {16'h5133, node_id, w_hd_dst, r_seq, 16'(w_hd_len), w_hd_trunc, 63'd0};

    assign pkt_cnt   = r_pkt_cnt;
    assign trunc_cnt = r_trunc_cnt;

    always_comb begin
        w_wr_next   = r_wr_state;
        in_ready    = 1'b0;
        w_pay_push  = 1'b0;
        w_desc_push = 1'b0;
        case (r_wr_state)
            WR_ACCEPT: begin
                in_ready = r_live & ~w_pay_full & ~w_desc_full;
                if (in_valid && r_live && !w_pay_full && !w_desc_full) begin
                    w_pay_push = 1'b1;
                    if (w_last_eff) begin
                        w_desc_push = 1'b1;
                        if (!in_last) w_wr_next = WR_DISCARD;
                    end
                end
            end
            WR_DISCARD: begin
                in_ready = 1'b1;
                if (in_valid && in_last) w_wr_next = WR_ACCEPT;
            end
            default: w_wr_next = WR_ACCEPT;
        endcase
    end

    always_comb begin
        w_rd_next  = r_rd_state;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        w_pay_pop  = 1'b0;
        w_desc_pop = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                if (!w_desc_empty && link_up) w_rd_next = RD_HDR;
            end
            RD_HDR: begin
                out_valid = 1'b1;
                out_data  = w_header;
                if (out_ready) w_rd_next = RD_PAY;
            end
            RD_PAY: begin
                out_valid = 1'b1;
                out_data  = w_pay_head[127:0];
                out_last  = w_pay_head[128];
                if (out_ready) begin
                    w_pay_pop = 1'b1;
                    if (w_pay_head[128]) begin
                        w_desc_pop = 1'b1;
                        w_rd_next  = RD_IDLE;
                    end
                end
            end
            default: w_rd_next = RD_IDLE;
        endcase
    end

    // Storage arrays carry no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_pay_push)  r_pay_mem[r_pay_wp[PAW-1:0]]    <= {w_last_eff, in_data};
        if (w_desc_push) r_desc_mem[r_desc_wp[DAW-1:0]]  <= {w_dst_cur, w_len_inc, ~in_last};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state  <= WR_ACCEPT;
            r_live      <= 1'b0;
            r_len       <= '0;
            r_dst       <= '0;
            r_pay_wp    <= '0;
            r_desc_wp   <= '0;
            r_trunc_cnt <= '0;
        end else begin
            r_wr_state <= w_wr_next;
            r_live     <= 1'b1;
            if (w_pay_push) begin
                r_pay_wp <= r_pay_wp + 1'b1;
                r_len    <= w_desc_push ? '0 : w_len_inc;
                if (r_len == '0) r_dst <= in_dst;
            end
            if (w_desc_push) begin
                r_desc_wp <= r_desc_wp + 1'b1;
                if (!in_last && r_trunc_cnt != 16'hFFFF) r_trunc_cnt <= r_trunc_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state <= RD_IDLE;
            r_pay_rp   <= '0;
            r_desc_rp  <= '0;
            r_seq      <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            r_rd_state <= w_rd_next;
            if (w_pay_pop) r_pay_rp <= r_pay_rp + 1'b1;
            if (w_desc_pop) begin
                r_desc_rp <= r_desc_rp + 1'b1;
                r_seq     <= r_seq + 1'b1;
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sl3_tx_framer.sv
// Directed bench for sl3_tx_framer: scoreboarded output phits plus cycle-exact
// checks of latency, bubbles, backpressure, truncation, full flags and reset.
module tb_sl3_tx_framer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   node_id;
    logic         link_up;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_last;
    logic [7:0]   in_dst;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_last;
    logic         out_ready;
    logic [31:0]  pkt_cnt;
    logic [15:0]  trunc_cnt;

    int           total = 0;
    int           bad   = 0;
    logic [128:0] exp_q[$];
    logic [15:0]  mseq;
    logic         mon_prev_stall = 1'b0;
    logic [128:0] mon_prev;
    bit           bp_on;
    bit           done_flag = 1'b0;

    always #5 clk = ~clk;

    sl3_tx_framer #(.FIFO_DEPTH(64), .MAX_PHITS(64), .DESC_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .node_id(node_id), .link_up(link_up),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_dst(in_dst),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .pkt_cnt(pkt_cnt),
        .trunc_cnt(trunc_cnt)
    );

    task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Output scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [128:0] e;
        if (!rst_n) begin
            mon_prev_stall = 1'b0;
        end else begin
            if (mon_prev_stall) begin
                chk("stall_valid", 129'(out_valid), 129'd1);
                chk("stall_hold", {out_last, out_data}, mon_prev);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_phit", 129'(exp_q.size()), 129'd1);
                else begin
                    e = exp_q.pop_front();
                    chk("out_phit", {out_last, out_data}, e);
                end
            end
            mon_prev_stall = out_valid && !out_ready;
            mon_prev       = {out_last, out_data};
        end
    end

    task automatic send_pkt(input logic [7:0] dst, input int n, output int stalls);
        int           len;
        int           t;
        logic [127:0] d;
        len    = (n > 64) ? 64 : n;
        stalls = 0;
        exp_q.push_back({1'b0, 16'h5133, node_id, dst, mseq, 16'(len), (n > 64), 63'd0});
        mseq++;
        for (int i = 0; i < n; i++) begin
            d        = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            in_data  = d;
            in_last  = (i == n - 1);
            in_dst   = (i == 0) ? dst : 8'hEE;
            if (i < 64) exp_q.push_back({(i == len - 1), d});
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 5000) begin
                stalls++;
                t++;
                @(negedge clk);
            end
            if (t >= 5000) chk("send_ready", 129'(in_ready), 129'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_idle", 129'(out_valid | (exp_q.size() != 0)), 129'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        chk("watchdog_done", 129'(done_flag), 129'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          stalls;
        int          base;
        logic [7:0]  pat;

        rst_n = 1'b0; node_id = 8'h02; link_up = 1'b1; out_ready = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_dst = '0; mseq = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_in_ready", 129'(in_ready), 129'd0);
        chk("rst_out_valid", 129'(out_valid), 129'd0);
        chk("rst_out_data", 129'(out_data), 129'd0);
        chk("rst_out_last", 129'(out_last), 129'd0);
        chk("rst_pkt_cnt", 129'(pkt_cnt), 129'd0);
        chk("rst_trunc_cnt", 129'(trunc_cnt), 129'd0);
        rst_n = 1'b1;
        chk("rel_in_ready_pre", 129'(in_ready), 129'd0);
        @(posedge clk); #1;
        chk("rel_in_ready", 129'(in_ready), 129'd1);

        // Single 3-phit packet, header two cycles after the last input phit.
        send_pkt(8'h07, 3, stalls);
        chk("t1_n1_idle", 129'(out_valid), 129'd0);
        @(posedge clk); #1;
        chk("t1_n2_valid", 129'(out_valid), 129'd1);
        chk("t1_header", 129'(out_data), 129'({64'h5133_0207_0000_0003, 64'h0}));
        chk("t1_hdr_last", 129'(out_last), 129'd0);
        wait_idle();
        chk("t1_pkt_cnt", 129'(pkt_cnt), 129'd1);

        // Oversize packet: truncated to 64 phits, tail dropped without stalling.
        send_pkt(8'h11, 70, stalls);
        chk("t2_no_stall", 129'(stalls), 129'd0);
        wait_idle();
        chk("t2_trunc_cnt", 129'(trunc_cnt), 129'd1);
        send_pkt(8'h12, 2, stalls);
        wait_idle();
        chk("t2_pkt_cnt", 129'(pkt_cnt), 129'd3);

        // Link gating, one bubble between buffered frames.
        link_up = 1'b0;
        send_pkt(8'h21, 2, stalls);
        send_pkt(8'h22, 1, stalls);
        repeat (5) @(posedge clk); #1;
        chk("t3_blocked", 129'(out_valid), 129'd0);
        link_up = 1'b1;
        pat = 8'b0110_1110;
        for (int i = 0; i < 8; i++) begin
            chk("t3_valid_pattern", 129'(out_valid), 129'(pat[i]));
            @(posedge clk); #1;
        end
        wait_idle();
        send_pkt(8'h23, 3, stalls);
        @(posedge clk); #1;
        chk("t3_hdr_started", 129'(out_valid), 129'd1);
        link_up = 1'b0;
        wait_idle();
        chk("t3_pkt_cnt", 129'(pkt_cnt), 129'd6);
        link_up = 1'b1;

        // Random backpressure over 100 random-length packets.
        base  = int'(pkt_cnt);
        bp_on = 1'b1;
        fork
            begin
                for (int p = 0; p < 100; p++)
                    send_pkt(8'(p), $urandom_range(1, 6), stalls);
                bp_on = 1'b0;
            end
            begin
                while (bp_on) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_idle();
        chk("t4_pkt_delta", 129'(int'(pkt_cnt) - base), 129'd100);

        // Descriptor FIFO full after four one-phit packets.
        out_ready = 1'b0;
        for (int p = 0; p < 4; p++) send_pkt(8'h40 + 8'(p), 1, stalls);
        chk("t5_full", 129'(in_ready), 129'd0);
        out_ready = 1'b1;
        chk("t5_hdr_cycle", 129'(in_ready), 129'd0);
        @(posedge clk); #1;
        chk("t5_pop_cycle", 129'(in_ready), 129'd0);
        @(posedge clk); #1;
        chk("t5_reassert", 129'(in_ready), 129'd1);
        wait_idle();

        // Reset mid-payload.
        send_pkt(8'h31, 6, stalls);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_in_payload", 129'(out_valid), 129'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        mseq = '0;
        #1;
        chk("t6_async_valid", 129'(out_valid), 129'd0);
        chk("t6_async_data", 129'(out_data), 129'd0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t6_pkt_cnt_rst", 129'(pkt_cnt), 129'd0);
        chk("t6_trunc_rst", 129'(trunc_cnt), 129'd0);
        @(posedge clk); #1;
        send_pkt(8'h32, 2, stalls);
        wait_idle();
        chk("t6_pkt_cnt", 129'(pkt_cnt), 129'd1);

        done_flag = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
